// File: rtl/zigzag_buffer.sv
// zigzag_buffer: ping-pong 8x8 coefficient store that accepts row-parallel
// writes and streams each completed block out serially in JPEG zigzag order.
module zigzag_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] data_in,
    input  logic [14:0] cnt_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [5:0]  out_index,
    output logic        out_last,
    output logic        overflow
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Zigzag position -> row*8+col address inside one bank.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [7:0] mem_q [128];
    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       wrBank_q;
    logic       rdBank_q;
    logic       overflow_q;
    state_t     state_q;
    logic       outValid_q;
    logic [7:0] outData_q;
    logic [5:0] outIndex_q;
    logic       outLast_q;

    logic [2:0] wrRow;
    logic       wrAccept;
    logic       wrDrop;
    logic       wrDone;
    logic       rdDone;
    logic       otherBank;
    logic [5:0] nextIndex;
    logic       unusedCntBits;

    // The upper counter bits belong to the wider pipeline and carry no meaning here.
    assign unusedCntBits = ^cnt_in[14:3];

    // Decode the incoming row, classify the write, and merge set/clear of the full flags.
    // A completing write and a completing read always refer to different banks,
    // because a write only lands in an empty bank and a read only drains a full one.
    always_comb begin
        wrRow     = cnt_in[2:0] - 3'd3;
        wrAccept  = in_valid && !full_q[wrBank_q];
        wrDrop    = in_valid && full_q[wrBank_q];
        wrDone    = wrAccept && (wrRow == 3'd7);
        rdDone    = (state_q == STREAM) && out_ready && (outIndex_q == 6'd63);
        otherBank = ~rdBank_q;
        nextIndex = outIndex_q + 6'd1;
        full_d    = full_q;
        if (wrDone) begin
            full_d[wrBank_q] = 1'b1;
        end
        if (rdDone) begin
            full_d[rdBank_q] = 1'b0;
        end
    end

    // Write-side bookkeeping: bank occupancy, write pointer and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q     <= 2'b00;
            wrBank_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wrDone) begin
                wrBank_q <= ~wrBank_q;
            end
            if (wrDrop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Coefficient storage; contents survive reset since the full flags gate their use.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            for (int c = 0; c < 8; c++) begin
                mem_q[{wrBank_q, wrRow, 3'(c)}] <= data_in[63 - 8*c -: 8];
            end
        end
    end

    // Read FSM with registered outputs; hands over to the other bank without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rdBank_q   <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= 8'd0;
            outIndex_q <= 6'd0;
            outLast_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (full_q[rdBank_q]) begin
                        state_q    <= STREAM;
                        outValid_q <= 1'b1;
                        outData_q  <= mem_q[{rdBank_q, ZIGZAG[0]}];
                        outIndex_q <= 6'd0;
                        outLast_q  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (outIndex_q != 6'd63) begin
                            outData_q  <= mem_q[{rdBank_q, ZIGZAG[nextIndex]}];
                            outIndex_q <= nextIndex;
                            outLast_q  <= (nextIndex == 6'd63);
                        end else begin
                            rdBank_q   <= otherBank;
                            outIndex_q <= 6'd0;
                            outLast_q  <= 1'b0;
                            if (full_q[otherBank]) begin
                                outData_q <= mem_q[{otherBank, ZIGZAG[0]}];
                            end else begin
                                state_q    <= IDLE;
                                outValid_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_index = outIndex_q;
    assign out_last  = outLast_q;
    assign overflow  = overflow_q;

endmodule
